// File: rtl/terminal_row_fetch.sv
// terminal_row_fetch
//
// Read side of the terminal cell store. One text row of COLUMNS 32-bit cells
// is burst-read from SDRAM into the back half of a ping-pong line buffer. The
// character renderer reads the front half by column index.
//
// Cell address map (shared with the cell writer):
//   {8'b0, row[5:0], col[6:0], 2'b00}, row pitch 128 cells.
//
// Optional feature macro: TERMINAL_FETCH_TIMEOUT_EN
//   When defined, a watchdog aborts a burst after TIMEOUT idle cycles in
//   RECEIVE. It sets fetch_error and still marks the row complete.
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   row_request       pulse: fetch row_index into the back buffer
//   row_index[5:0]    row to fetch, sampled when the request is accepted
//   row_swap          pulse at a line boundary: promote a complete back buffer
//   busy              high in REQUEST/RECEIVE; requests are dropped while high
//   row_ready         one-cycle pulse when the back buffer becomes complete
//   fetch_error       sticky: short burst, out-of-range row or timeout
//   underrun          one-cycle pulse (the cycle after row_swap) when the
//                     swap found the back buffer incomplete
//   rd_address[22:0]  SDRAM word address of the first cell of the row
//   rd_request        one-cycle read request per fetch
//   rd_burst_length   constant COLUMNS
//   rd_data, rd_data_valid, rd_done   SDRAM read return
//   cell_column[6:0]  front-buffer column to read
//   cell_data[31:0]   front-buffer cell, registered (one-cycle latency)
//   fetch_state[1:0]  current FSM state, for debug/observation
//
// Handshake: the SDRAM side sees rd_request high for exactly one cycle with
// rd_address/rd_burst_length stable in that cycle; there is no ready/ack. Every
// cycle with rd_data_valid high in RECEIVE carries one word, and rd_done ends
// the burst (a word in the same cycle is still written).

module terminal_row_fetch #(
    parameter int COLUMNS = 80,
    parameter int ROWS    = 51,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        row_request,
    input  logic [5:0]  row_index,
    input  logic        row_swap,
    output logic        busy,
    output logic        row_ready,
    output logic        fetch_error,
    output logic        underrun,
    output logic [22:0] rd_address,
    output logic        rd_request,
    output logic [8:0]  rd_burst_length,
    input  logic [31:0] rd_data,
    input  logic        rd_data_valid,
    input  logic        rd_done,
    input  logic [6:0]  cell_column,
    output logic [31:0] cell_data,
    output logic [1:0]  fetch_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        RECEIVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [7:0] COLS_W = 8'(COLUMNS);
    localparam logic [6:0] ROWS_W = 7'(ROWS);

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        range_err;
    logic        timeout_hit;
    logic        wr_en;
    logic        complete_now;
    logic [7:0]  word_cnt;
    logic        front_sel;
    logic        back_complete;

    // Two halves of 128 entries each, selected by the top address bit.
    logic [31:0] line_buf [0:255];

    assign busy            = (state == REQUEST) || (state == RECEIVE);
    assign rd_request      = (state == REQUEST);
    assign row_ready       = (state == DONE);
    assign rd_burst_length = 9'(COLUMNS);
    assign fetch_state     = state;

    // Words past COLUMNS are dropped and the counter saturates there.
    assign wr_en = (state == RECEIVE) && rd_data_valid && (word_cnt < COLS_W);

    // Completion in DONE counts as complete in the same cycle, so a swap
    // coinciding with DONE promotes the new row instead of underrunning.
    assign complete_now = back_complete || (state == DONE);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        range_err  = 1'b0;
        case (state)
            IDLE: begin
                if (row_request) begin
                    if ({1'b0, row_index} >= ROWS_W) begin
                        range_err = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = REQUEST;
                    end
                end
            end
            REQUEST: state_next = RECEIVE;
            RECEIVE: begin
                if (rd_done || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_address    <= '0;
            word_cnt      <= '0;
            front_sel     <= 1'b0;
            back_complete <= 1'b0;
            fetch_error   <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            underrun <= row_swap && !complete_now;

            if (accept) begin
                rd_address <= {8'b0, row_index, 7'b0, 2'b00};
            end

            if (state == REQUEST) begin
                word_cnt      <= '0;
                back_complete <= 1'b0;
            end else if (wr_en) begin
                word_cnt <= word_cnt + 8'd1;
            end

            if (range_err || timeout_hit) begin
                fetch_error <= 1'b1;
            end
            if ((state == DONE) && (word_cnt != COLS_W)) begin
                fetch_error <= 1'b1;
            end

            // Later assignments win over the REQUEST clear above.
            if (row_swap && complete_now) begin
                front_sel     <= ~front_sel;
                back_complete <= 1'b0;
            end else if (state == DONE) begin
                back_complete <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffer: write into the back half, registered read of the front
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_buf[{~front_sel, word_cnt[6:0]}] <= rd_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cell_data <= '0;
        end else if ({1'b0, cell_column} < COLS_W) begin
            cell_data <= line_buf[{front_sel, cell_column}];
        end else begin
            cell_data <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Optional watchdog
    // ------------------------------------------------------------------
`ifdef TERMINAL_FETCH_TIMEOUT_EN
    localparam int             WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    logic [WD_W-1:0] wdog;

    // Counts idle cycles in RECEIVE; any data word restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog <= '0;
        end else if ((state != RECEIVE) || rd_data_valid) begin
            wdog <= '0;
        end else if (wdog != WD_LIMIT) begin
            wdog <= wdog + WD_W'(1);
        end
    end

    assign timeout_hit = (state == RECEIVE) && !rd_data_valid && (wdog == WD_LIMIT);
`else
    // Watchdog disabled: RECEIVE waits for rd_done indefinitely.
    localparam int TIMEOUT_UNUSED = TIMEOUT;
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_terminal_row_fetch.sv
module tb_terminal_row_fetch;

    logic        clk;
    logic        reset_n;
    logic        row_request;
    logic [5:0]  row_index;
    logic        row_swap;
    logic        busy;
    logic        row_ready;
    logic        fetch_error;
    logic        underrun;
    logic [22:0] rd_address;
    logic        rd_request;
    logic [8:0]  rd_burst_length;
    logic [31:0] rd_data;
    logic        rd_data_valid;
    logic        rd_done;
    logic [6:0]  cell_column;
    logic [31:0] cell_data;
    logic [1:0]  fetch_state;

    logic        cell_req;

    int tests_run = 0;
    int fails     = 0;

    // Scoreboard queues
    logic [22:0] exp_addr_q[$];
    logic [31:0] exp_cell_q[$];
    logic        exp_ready_q[$];
    logic        exp_under_q[$];

    terminal_row_fetch dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .row_request     (row_request),
        .row_index       (row_index),
        .row_swap        (row_swap),
        .busy            (busy),
        .row_ready       (row_ready),
        .fetch_error     (fetch_error),
        .underrun        (underrun),
        .rd_address      (rd_address),
        .rd_request      (rd_request),
        .rd_burst_length (rd_burst_length),
        .rd_data         (rd_data),
        .rd_data_valid   (rd_data_valid),
        .rd_done         (rd_done),
        .cell_column     (cell_column),
        .cell_data       (cell_data),
        .fetch_state     (fetch_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        tests_run++;
        fails++;
        $display("FAIL %s: unexpected event", name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"},        32'(busy), 32'd0);
        check({tag, " row_ready"},   32'(row_ready), 32'd0);
        check({tag, " fetch_error"}, 32'(fetch_error), 32'd0);
        check({tag, " underrun"},    32'(underrun), 32'd0);
        check({tag, " rd_request"},  32'(rd_request), 32'd0);
        check({tag, " rd_address"},  32'(rd_address), 32'd0);
        check({tag, " burst_len"},   32'(rd_burst_length), 32'd80);
        check({tag, " cell_data"},   cell_data, 32'd0);
        check({tag, " state"},       32'(fetch_state), 32'd0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [22:0] ea;
        logic [31:0] ec;
        logic        tok;
        forever begin
            @(posedge clk);
            #1;
            if (rd_request) begin
                if (exp_addr_q.size() == 0) begin
                    fail_evt("rd_request");
                end else begin
                    ea = exp_addr_q.pop_front();
                    check("rd_address", 32'(rd_address), 32'(ea));
                    check("rd_burst_length", 32'(rd_burst_length), 32'd80);
                end
            end
            if (row_ready) begin
                if (exp_ready_q.size() == 0) fail_evt("row_ready");
                else tok = exp_ready_q.pop_front();
            end
            if (underrun) begin
                if (exp_under_q.size() == 0) fail_evt("underrun");
                else tok = exp_under_q.pop_front();
            end
            if (cell_req) begin
                if (exp_cell_q.size() == 0) begin
                    fail_evt("cell_read");
                end else begin
                    ec = exp_cell_q.pop_front();
                    check("cell_data", cell_data, ec);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic request(input logic [5:0] r);
        @(negedge clk);
        row_index   = r;
        row_request = 1'b1;
        @(negedge clk);
        row_request = 1'b0;
    endtask

    task automatic feed(input int n, input logic [31:0] base, input bit with_done);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rd_data       = base + 32'(i);
            rd_data_valid = 1'b1;
            rd_done       = with_done && (i == n - 1);
        end
        @(negedge clk);
        rd_data_valid = 1'b0;
        rd_done       = 1'b0;
    endtask

    task automatic swap_pulse(input bit expect_underrun);
        @(negedge clk);
        row_swap = 1'b1;
        if (expect_underrun) exp_under_q.push_back(1'b1);
        @(negedge clk);
        row_swap = 1'b0;
    endtask

    task automatic read_cell(input logic [6:0] col, input logic [31:0] exp);
        @(negedge clk);
        cell_column = col;
        cell_req    = 1'b1;
        exp_cell_q.push_back(exp);
        @(negedge clk);
        cell_req = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle_cycles(2);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        idle_cycles(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n       = 1'b0;
        row_request   = 1'b0;
        row_index     = '0;
        row_swap      = 1'b0;
        rd_data       = '0;
        rd_data_valid = 1'b0;
        rd_done       = 1'b0;
        cell_column   = '0;
        cell_req      = 1'b0;

        idle_cycles(3);
        check_reset_outputs("init");
        reset_n = 1'b1;
        idle_cycles(2);

        // Row 3: full burst into half 1, then swap it to the front.
        exp_addr_q.push_back(23'h000600);
        request(6'd3);
        check("busy_in_request", 32'(busy), 32'd1);
        exp_ready_q.push_back(1'b1);
        feed(80, 32'hC000_0000, 1'b1);
        idle_cycles(2);
        check("busy_after_done", 32'(busy), 32'd0);
        check("no_error_full", 32'(fetch_error), 32'd0);
        swap_pulse(1'b0);
        read_cell(7'd5,  32'hC000_0005);
        read_cell(7'd79, 32'hC000_004F);
        read_cell(7'd80, 32'h0000_0000);
        read_cell(7'd0,  32'hC000_0000);

        // Row 4: swap and request while receiving; front must stay row 3.
        exp_addr_q.push_back(23'h000800);
        request(6'd4);
        feed(40, 32'hD000_0000, 1'b0);
        swap_pulse(1'b1);
        request(6'd7);                // dropped: busy
        check("busy_receive", 32'(busy), 32'd1);
        exp_ready_q.push_back(1'b1);
        feed(40, 32'hD000_0028, 1'b1);
        read_cell(7'd5, 32'hC000_0005);
        swap_pulse(1'b0);
        read_cell(7'd5,  32'hD000_0005);
        read_cell(7'd79, 32'hD000_004F);

        // Row 10: swap lands in the DONE cycle -> swap, no underrun.
        exp_addr_q.push_back(23'h001400);
        request(6'd10);
        exp_ready_q.push_back(1'b1);
        feed(80, 32'hE000_0000, 1'b1);
        row_swap = 1'b1;              // this cycle is DONE
        @(negedge clk);
        row_swap = 1'b0;
        read_cell(7'd5,  32'hE000_0005);
        read_cell(7'd79, 32'hE000_004F);

        // Row 20: 82 words, last two dropped, no error.
        exp_addr_q.push_back(23'h002800);
        request(6'd20);
        exp_ready_q.push_back(1'b1);
        feed(82, 32'hF000_0000, 1'b1);
        idle_cycles(1);
        check("no_error_long", 32'(fetch_error), 32'd0);
        swap_pulse(1'b0);
        read_cell(7'd0,  32'hF000_0000);
        read_cell(7'd79, 32'hF000_004F);

        // Row 50: 78 words -> error, row still completes; cols 78/79 stale
        // from row 10 which occupied the same half.
        exp_addr_q.push_back(23'h006400);
        request(6'd50);
        exp_ready_q.push_back(1'b1);
        feed(78, 32'h1000_0000, 1'b1);
        idle_cycles(1);
        check("error_short", 32'(fetch_error), 32'd1);
        swap_pulse(1'b0);
        read_cell(7'd77, 32'h1000_004D);
        read_cell(7'd78, 32'hE000_004E);

        // Out-of-range row after a clean reset.
        apply_reset();
        request(6'd51);
        check("range_busy", 32'(busy), 32'd0);
        check("range_state", 32'(fetch_state), 32'd0);
        idle_cycles(2);
        check("range_error", 32'(fetch_error), 32'd1);

        // Reset in the middle of a burst.
        apply_reset();
        exp_addr_q.push_back(23'h000600);
        request(6'd3);
        feed(40, 32'hAAAA_0000, 1'b0);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midburst");
        @(negedge clk);
        reset_n = 1'b1;
        idle_cycles(1);

        // Clean fetch after reset: front select restarts at 0.
        exp_addr_q.push_back(23'h000200);
        request(6'd1);
        exp_ready_q.push_back(1'b1);
        feed(80, 32'h2000_0000, 1'b1);
        swap_pulse(1'b0);
        read_cell(7'd0,  32'h2000_0000);
        read_cell(7'd63, 32'h2000_003F);
        check("clean_error", 32'(fetch_error), 32'd0);

`ifdef TERMINAL_FETCH_TIMEOUT_EN
        // Stall mid-burst beyond the watchdog limit.
        exp_addr_q.push_back(23'h000400);
        request(6'd2);
        exp_ready_q.push_back(1'b1);
        feed(10, 32'h3000_0000, 1'b0);
        idle_cycles(1100);
        check("timeout_error", 32'(fetch_error), 32'd1);
        check("timeout_state", 32'(fetch_state), 32'd0);
`endif

        idle_cycles(4);
        check("pending_addr",  32'(exp_addr_q.size()),  32'd0);
        check("pending_ready", 32'(exp_ready_q.size()), 32'd0);
        check("pending_under", 32'(exp_under_q.size()), 32'd0);
        check("pending_cell",  32'(exp_cell_q.size()),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
